// File: rtl/pipelined_adder_subtractor.sv
// Segmented-carry pipelined two's-complement adder/subtractor with valid/ready handshake.
// Define ADDSUB_SAT_EN to clamp overflowing results to the signed max/min.
module pipelined_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG_W;

  if ((SEG_W < 1) || (WIDTH % SEG_W != 0)) begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of SEG_W");
  end

  // The whole pipeline advances together; a stalled output freezes every stage.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM  = WIDTH - k * SEG_W;
    localparam int DONE = (k + 1) * SEG_W;

    logic [REM-1:0]   op_a;
    logic [REM-1:0]   op_b;
    logic             c_in;
    logic             v_in;
    logic [SEG_W:0]   seg;
    logic [DONE-1:0]  sum_nxt;

    // Each stage carries only the operand bits still to be added, plus finished sum bits.
    if (k == 0) begin : g_src
      assign op_a    = a;
      assign op_b    = b ^ {WIDTH{sub}};
      assign c_in    = sub;
      assign v_in    = in_valid;
      assign sum_nxt = seg[SEG_W-1:0];
    end else begin : g_src
      assign op_a    = g_stage[k-1].g_reg.a_q;
      assign op_b    = g_stage[k-1].g_reg.b_q;
      assign c_in    = g_stage[k-1].g_reg.c_q;
      assign v_in    = g_stage[k-1].g_reg.v_q;
      assign sum_nxt = {seg[SEG_W-1:0], g_stage[k-1].g_reg.sum_q};
    end

    assign seg = {1'b0, op_a[SEG_W-1:0]} + {1'b0, op_b[SEG_W-1:0]} + {{SEG_W{1'b0}}, c_in};

    if (k < STAGES - 1) begin : g_reg
      logic [REM-SEG_W-1:0] a_q;
      logic [REM-SEG_W-1:0] b_q;
      logic [DONE-1:0]      sum_q;
      logic                 c_q;
      logic                 v_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
          c_q   <= 1'b0;
          v_q   <= 1'b0;
        end else if (en) begin
          a_q   <= op_a[REM-1:SEG_W];
          b_q   <= op_b[REM-1:SEG_W];
          sum_q <= sum_nxt;
          c_q   <= seg[SEG_W];
          v_q   <= v_in;
        end
      end
    end else begin : g_out
      logic             ovf_nxt;
      logic [WIDTH-1:0] res_nxt;

      assign ovf_nxt = (op_a[REM-1] == op_b[REM-1]) && (sum_nxt[WIDTH-1] != op_a[REM-1]);

`ifdef ADDSUB_SAT_EN
      assign res_nxt = !ovf_nxt    ? sum_nxt :
                       op_a[REM-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign res_nxt = sum_nxt;
`endif

      // Bubbles leave result/cout/ovf holding the last delivered value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          result    <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (en) begin
          out_valid <= v_in;
          if (v_in) begin
            result <= res_nxt;
            cout   <= seg[SEG_W];
            ovf    <= ovf_nxt;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder_subtractor.sv
// Directed self-checking bench for pipelined_adder_subtractor (WIDTH=16, SEG_W=4).
module tb_pipelined_adder_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  pipelined_adder_subtractor #(.WIDTH(16), .SEG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: plain 17-bit add, independent of any segmentation.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic msub);
    logic [15:0] bp;
    logic [16:0] s;
    logic        o;
    logic [15:0] r;
    bp = mb ^ {16{msub}};
    s  = {1'b0, ma} + {1'b0, bp} + {16'd0, msub};
    o  = (ma[15] == bp[15]) && (s[15] != ma[15]);
    r  = s[15:0];
`ifdef ADDSUB_SAT_EN
    if (o) r = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {r, s[16], o};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_and_wait(input logic [15:0] ta, input logic [15:0] tbv, input logic tsub, output int lat);
    a = ta;
    b = tbv;
    sub = tsub;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 16'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected 0000", result); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("[TB] FAIL reset_cout_ovf: got %b expected 00", {cout, ovf}); end
    out_ready = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_add;
    int lat;
    issue_and_wait(16'h1234, 16'h1111, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL add_latency: got %0d expected 4", lat); end
    checks++; if ({result, cout, ovf} !== {16'h2345, 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL add_basic: got %h/%b/%b expected 2345/0/0", result, cout, ovf); end
    tick;
    issue_and_wait(16'hFFFF, 16'h0001, 1'b0, lat);
    checks++; if ({result, cout, ovf} !== {16'h0000, 1'b1, 1'b0})
      begin errors++; $display("[TB] FAIL add_carry_ripple: got %h/%b/%b expected 0000/1/0", result, cout, ovf); end
    tick;
  endtask

  task automatic test_overflow;
    int lat;
    logic [15:0] exp_r;
`ifdef ADDSUB_SAT_EN
    exp_r = 16'h7FFF;
`else
    exp_r = 16'h8000;
`endif
    issue_and_wait(16'h7FFF, 16'h0001, 1'b0, lat);
    checks++; if ({result, cout, ovf} !== {exp_r, 1'b0, 1'b1})
      begin errors++; $display("[TB] FAIL add_overflow: got %h/%b/%b expected %h/0/1", result, cout, ovf, exp_r); end
    tick;
  endtask

  task automatic test_subtract;
    int lat;
    logic [15:0] exp_r;
`ifdef ADDSUB_SAT_EN
    exp_r = 16'h8000;
`else
    exp_r = 16'h7FFF;
`endif
    issue_and_wait(16'h0000, 16'h0001, 1'b1, lat);
    checks++; if ({result, cout, ovf} !== {16'hFFFF, 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL sub_borrow: got %h/%b/%b expected ffff/0/0", result, cout, ovf); end
    tick;
    issue_and_wait(16'h8000, 16'h0001, 1'b1, lat);
    checks++; if ({result, cout, ovf} !== {exp_r, 1'b1, 1'b1})
      begin errors++; $display("[TB] FAIL sub_overflow: got %h/%b/%b expected %h/1/1", result, cout, ovf, exp_r); end
    tick;
    issue_and_wait(16'h0F0F, 16'h0F0F, 1'b1, lat);
    checks++; if ({result, cout, ovf} !== {16'h0000, 1'b1, 1'b0})
      begin errors++; $display("[TB] FAIL sub_equal: got %h/%b/%b expected 0000/1/0", result, cout, ovf); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [15:0] ta [8];
    logic [15:0] tbv [8];
    logic        ts [8];
    logic [17:0] exp;
    logic        exp_v;
    for (int i = 0; i < 8; i++) begin
      ta[i]  = 16'hF00F + 16'(i) * 16'h1234;
      tbv[i] = 16'h0FF1 ^ (16'(i) * 16'h2108);
      ts[i]  = i[0];
    end
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) begin
        a = ta[c]; b = tbv[c]; sub = ts[c]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready c=%0d: got %b expected 1", c, in_ready); end
      tick;
      exp_v = (c >= 3) && (c <= 10);
      checks++; if (out_valid !== exp_v) begin errors++; $display("[TB] FAIL b2b_out_valid c=%0d: got %b expected %b", c, out_valid, exp_v); end
      if (exp_v) begin
        exp = model(ta[c-3], tbv[c-3], ts[c-3]);
        checks++; if ({result, cout, ovf} !== exp)
          begin errors++; $display("[TB] FAIL b2b_result c=%0d: got %h expected %h", c, {result, cout, ovf}, exp); end
      end
    end
  endtask

  task automatic test_stall;
    logic [15:0] ta [6];
    logic [15:0] tbv [6];
    logic        ts [6];
    logic [17:0] exp;
    logic        fire_in;
    logic        fire_out;
    int          send;
    int          recv;
    int          c;
    for (int i = 0; i < 6; i++) begin
      ta[i]  = 16'h0123 * 16'(i + 1);
      tbv[i] = 16'h7654 - 16'(i) * 16'h0311;
      ts[i]  = (i % 3 == 1);
    end
    send = 0;
    recv = 0;
    c = 0;
    while (c < 40 && recv < 6) begin
      out_ready = (c >= 9);
      if (send < 6) begin
        a = ta[send]; b = tbv[send]; sub = ts[send]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 4 && c <= 8) begin
        exp = model(ta[0], tbv[0], ts[0]);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_out_valid c=%0d: got %b expected 1", c, out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready c=%0d: got %b expected 0", c, in_ready); end
        checks++; if ({result, cout, ovf} !== exp)
          begin errors++; $display("[TB] FAIL stall_hold c=%0d: got %h expected %h", c, {result, cout, ovf}, exp); end
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        exp = model(ta[recv], tbv[recv], ts[recv]);
        checks++; if ({result, cout, ovf} !== exp)
          begin errors++; $display("[TB] FAIL stall_drain op=%0d: got %h expected %h", recv, {result, cout, ovf}, exp); end
        recv++;
      end
      tick;
      if (fire_in) send++;
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (recv !== 6) begin errors++; $display("[TB] FAIL stall_count: got %0d expected 6", recv); end
    tick;
  endtask

  task automatic test_reset_midstream;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 16'h7FFF : 16'hFFFF;
      b = 16'h0001;
      sub = 1'b0;
      in_valid = 1'b1;
      tick;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre_valid: got %b expected 1", out_valid); end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if ({result, cout, ovf} !== 18'h0)
      begin errors++; $display("[TB] FAIL mid_outputs: got %h/%b/%b expected 0000/0/0", result, cout, ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale c=%0d: got %b expected 0", c, out_valid); end
    end
    issue_and_wait(16'h0001, 16'h0002, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL mid_fresh_latency: got %0d expected 4", lat); end
    checks++; if ({result, cout, ovf} !== {16'h0003, 1'b0, 1'b0})
      begin errors++; $display("[TB] FAIL mid_fresh_result: got %h/%b/%b expected 0003/0/0", result, cout, ovf); end
    tick;
  endtask

  initial begin
    $display("[TB] starting");
    test_reset;
    test_add;
    test_overflow;
    test_subtract;
    test_back_to_back;
    tick;
    tick;
    test_stall;
    tick;
    test_reset_midstream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
